mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 32, address width of all ports
  DATA_W, 32, data width of all ports
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state changes on rising edge
  reset  input  1  asynchronous, active-low reset
  if_req  input  1  fetch request, held until if_ack
  if_addr  input  ADDR_W  fetch address (pc)
  if_rdata  output  DATA_W  fetch read data
  if_ack  output  1  fetch completion pulse
  d_req  input  1  data request, held until d_ack
  d_we  input  1  data write enable (store)
  d_addr  input  ADDR_W  data address (alu_result)
  d_wdata  input  DATA_W  store data
  d_rdata  output  DATA_W  load read data
  d_ack  output  1  data completion pulse
  mem_en  output  1  memory access strobe
  mem_we  output  1  memory write strobe
  mem_addr  output  ADDR_W  memory address
  mem_wdata  output  DATA_W  memory write data
  mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en
  busy  output  1  transaction in progress

Function
REQ-003 The block SHALL share one single-port synchronous memory between the fetch port and the data port.
REQ-004 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-005 Transitions:
  - IDLE->ACCESS when if_req or d_req is 1; else stay in IDLE.
  - ACCESS->RESP unconditionally.
  - RESP->IDLE unconditionally.
REQ-006 On the IDLE->ACCESS edge the block SHALL register the grant, address, d_we and d_wdata of the winning port.
REQ-007 In ACCESS: mem_en=1; mem_we=registered d_we if the data port won, else 0; mem_addr and mem_wdata come from the registered values.
REQ-008 Outside ACCESS: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last registered values.
REQ-009 In RESP the granted port's ack SHALL be 1 for exactly one cycle, and mem_rdata SHALL be captured into that port's rdata register.
REQ-010 On a write, d_rdata SHALL be left unchanged.
REQ-011 if_rdata and d_rdata SHALL hold their value until the next ack on the same port.
REQ-012 Latency SHALL be 3 cycles from req sampled in IDLE to ack; peak throughput is one transaction per 3 cycles.
REQ-013 A requester SHALL either drop req or present a new transaction in the cycle after its ack; a req seen in IDLE is always a new transaction.
REQ-014 If only one port requests in IDLE, that port SHALL win.
REQ-015 If both ports request in IDLE, the tie SHALL be resolved per REQ-021/REQ-022.
REQ-016 The losing port SHALL be served at its next IDLE, with no request dropped or duplicated.
REQ-017 busy SHALL be 1 in ACCESS and RESP, and 0 in IDLE.
REQ-018 Changes on the inputs of the non-granted port during a transaction SHALL have no effect on that transaction.

Reset
REQ-019 Assertion of reset (low) SHALL immediately, without waiting for clk, force:
  - state to IDLE
  - mem_en, mem_we, if_ack, d_ack, busy to 0
  - mem_addr, mem_wdata, if_rdata, d_rdata to 0
  - the last-grant register to "data"
REQ-020 A transaction in flight when reset asserts SHALL be abandoned with no ack; after reset deasserts, arbitration restarts in IDLE on the next rising edge.

Configuration
REQ-021 With MEM_ARB_RR_EN defined: a tie SHALL go to the port not granted last (round-robin via the last-grant register, updated on every grant), so the fetch port wins the first tie after reset.
REQ-022 Without MEM_ARB_RR_EN: a tie SHALL always go to the data port, and the last-grant register SHALL not be implemented.

Verification
REQ-023 Single fetch:
  - stimulus: if_req=1, if_addr=0x10, memory word 0x10 = 0x00500093
  - response: mem_en=1 with mem_addr=0x10 in cycle 1; if_ack=1 and if_rdata=0x00500093 in cycle 2; busy=0 in cycle 3.
REQ-024 Store then load:
  - stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF; then a load from 0x40.
  - response: mem_we=1 for exactly one cycle during the store; the load returns d_rdata=0xDEADBEEF; d_rdata is unchanged after the store's ack.
REQ-025 Tie with MEM_ARB_RR_EN:
  - stimulus: if_req and d_req both held at 1 from reset release.
  - response: grants alternate fetch, data, fetch, data, with an ack every 3 cycles.
REQ-026 Tie without MEM_ARB_RR_EN:
  - stimulus: same as REQ-025, with d_req dropped after 2 acks.
  - response: the first two grants go to data; the fetch ack arrives at cycle 8.
REQ-027 Reset mid-access:
  - stimulus: reset driven low during ACCESS of a write to 0x80.
  - response: mem_en, mem_we and busy go to 0 asynchronously; no ack is produced; the next request after release completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter sharing one single-port synchronous memory (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_RR_EN for round-robin tie-break; by default a tie always goes to the data port.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              start, win_d, gnt_d, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, if_rdata_r, d_rdata_r;

  assign start = (state == IDLE) && (if_req || d_req);

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when the data port took the previous grant; resets to data so fetch wins the first tie
  logic last_d;
  assign win_d = d_req && (!if_req || !last_d);

  always_ff @(posedge clk or negedge reset)
    if (!reset)     last_d <= 1'b1;
    else if (start) last_d <= win_d;
`else
  assign win_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction is frozen at grant, so the other port's inputs cannot disturb it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gnt_d      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      if (start) begin
        gnt_d  <= win_d;
        we_r   <= win_d && d_we;
        addr_r <= win_d ? d_addr : if_addr;
        if (win_d) wdata_r <= d_wdata;
      end
      if (state == RESP) begin
        if (!gnt_d)     if_rdata_r <= mem_rdata;
        else if (!we_r) d_rdata_r  <= mem_rdata;
      end
    end

  // Read data is forwarded straight from memory during the ack cycle, then held in the register
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if_ack   = 1'b0;
    d_ack    = 1'b0;
    busy     = 1'b0;
    if_rdata = if_rdata_r;
    d_rdata  = d_rdata_r;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = gnt_d && we_r;
        busy   = 1'b1;
      end
      RESP: begin
        busy   = 1'b1;
        if_ack = !gnt_d;
        d_ack  = gnt_d;
        if (!gnt_d)     if_rdata = mem_rdata;
        else if (!we_r) d_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule
